// File: rtl/secuenciador_suma.sv
// Keypad-driven BCD adder sequencer: assembles operands A and B digit by digit,
// runs a digit-serial BCD add (one digit per cycle, LSD first) and holds the result.
module secuenciador_suma #(
  parameter int DIGITS = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         key_valid,
  input  logic [3:0]                   key,
  output logic [4*DIGITS-1:0]          operand_a,
  output logic [4*DIGITS-1:0]          operand_b,
  output logic [4*DIGITS-1:0]          resultado,
  output logic                         overflow,
  output logic [4*DIGITS-1:0]          display,
  output logic [$clog2(DIGITS+1)-1:0]  num_digits,
  output logic [1:0]                   fase,
  output logic                         busy,
  output logic                         done
);

  localparam int W  = 4 * DIGITS;
  localparam int NW = $clog2(DIGITS + 1);
  localparam int IW = $clog2(DIGITS);

  typedef enum logic [1:0] {
    ENTRY_A = 2'd0,
    ENTRY_B = 2'd1,
    ADD     = 2'd2,
    DONE    = 2'd3
  } fase_t;

  fase_t          fase_q, fase_d;
  logic [W-1:0]   opa_q, opa_d;
  logic [W-1:0]   opb_q, opb_d;
  logic [W-1:0]   res_q, res_d;
  logic           ovf_q, ovf_d;
  logic [NW-1:0]  nd_q, nd_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           carry_q, carry_d;
  logic           done_q, done_d;

  logic [3:0]     a_dig_v [DIGITS];
  logic [3:0]     b_dig_v [DIGITS];
  logic [3:0]     a_dig, b_dig, sum_dig;
  logic [4:0]     sum5;
  logic           cout;
  logic           key_digit, key_enter, key_clear, clr;
  logic           room;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_dig
    assign a_dig_v[gi] = opa_q[4*gi +: 4];
    assign b_dig_v[gi] = opb_q[4*gi +: 4];
  end

  assign a_dig     = a_dig_v[idx_q];
  assign b_dig     = b_dig_v[idx_q];
  assign key_digit = key_valid && (key <= 4'd9);
  assign key_enter = key_valid && (key == 4'hA);
  assign key_clear = key_valid && (key == 4'hB);
  assign room      = (nd_q < NW'(DIGITS));

  // Decimal adjust of one digit: sums 10..19 wrap to 0..9 with a carry.
  always_comb begin
    sum5    = {1'b0, a_dig} + {1'b0, b_dig} + {4'b0000, carry_q};
    sum_dig = sum5[3:0];
    cout    = 1'b0;
    if (sum5 > 5'd9) begin
      sum_dig = sum5[3:0] - 4'd10;
      cout    = 1'b1;
    end
  end

  always_comb begin
    fase_d  = fase_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    nd_d    = nd_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    done_d  = 1'b0;
    clr     = 1'b0;

    case (fase_q)
      ENTRY_A: begin
        if (key_clear) begin
          clr = 1'b1;
        end else if (key_digit && room) begin
          opa_d = {opa_q[W-5:0], key};
          nd_d  = nd_q + NW'(1);
        end else if (key_enter) begin
          fase_d = ENTRY_B;
          nd_d   = '0;
        end
      end
      ENTRY_B: begin
        if (key_clear) begin
          clr = 1'b1;
        end else if (key_digit && room) begin
          opb_d = {opb_q[W-5:0], key};
          nd_d  = nd_q + NW'(1);
        end else if (key_enter) begin
          fase_d  = ADD;
          idx_d   = '0;
          carry_d = 1'b0;
          res_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      ADD: begin
        res_d[{idx_q, 2'b00} +: 4] = sum_dig;
        carry_d = cout;
        idx_d   = idx_q + IW'(1);
        if (idx_q == IW'(DIGITS - 1)) begin
          ovf_d   = cout;
          fase_d  = DONE;
          done_d  = 1'b1;
          idx_d   = '0;
          carry_d = 1'b0;
        end
      end
      DONE: begin
        if (key_clear) begin
          clr = 1'b1;
        end else if (key_digit) begin
          opa_d  = {{(W-4){1'b0}}, key};
          opb_d  = '0;
          res_d  = '0;
          ovf_d  = 1'b0;
          nd_d   = NW'(1);
          fase_d = ENTRY_A;
        end else if (key_enter) begin
          // Chaining: the previous sum becomes operand A of the next add.
          opa_d  = res_q;
          opb_d  = '0;
          ovf_d  = 1'b0;
          nd_d   = '0;
          fase_d = ENTRY_B;
        end
      end
      default: fase_d = ENTRY_A;
    endcase

    if (clr) begin
      fase_d  = ENTRY_A;
      opa_d   = '0;
      opb_d   = '0;
      res_d   = '0;
      ovf_d   = 1'b0;
      nd_d    = '0;
      idx_d   = '0;
      carry_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fase_q  <= ENTRY_A;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      nd_q    <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      fase_q  <= fase_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      nd_q    <= nd_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    case (fase_q)
      ENTRY_A: display = opa_q;
      DONE:    display = res_q;
      default: display = opb_q;
    endcase
  end

  assign operand_a  = opa_q;
  assign operand_b  = opb_q;
  assign resultado  = res_q;
  assign overflow   = ovf_q;
  assign num_digits = nd_q;
  assign fase       = fase_q;
  assign busy       = (fase_q == ADD);
  assign done       = done_q;

endmodule

// File: tb/tb_secuenciador_suma.sv
// Bench for secuenciador_suma: integer-valued calculator model plus a scoreboard
// of expected sums, checked by a negedge monitor.
module tb_secuenciador_suma;

  localparam int D  = 4;
  localparam int W  = 4 * D;
  localparam int NW = $clog2(D + 1);
  localparam int P  = 10 ** D;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            key_valid = 1'b0;
  logic [3:0]      key = 4'h0;
  logic [W-1:0]    operand_a, operand_b, resultado, display;
  logic            overflow, busy, done;
  logic [NW-1:0]   num_digits;
  logic [1:0]      fase;

  secuenciador_suma #(.DIGITS(D)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key(key),
    .operand_a(operand_a), .operand_b(operand_b), .resultado(resultado),
    .overflow(overflow), .display(display), .num_digits(num_digits),
    .fase(fase), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         ovf;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } exp_t;

  exp_t sb[$];

  int  vectors = 0;
  int  miscompares = 0;
  bit  mon_en = 1'b0;

  // Model state: mode 0=entry A, 1=entry B, 2=adding, 3=done; values held as integers.
  int  m_mode, m_nd, m_cnt, m_a, m_b, m_res;
  bit  m_ovf, m_done;

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < D; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic void model_reset();
    m_mode = 0; m_nd = 0; m_cnt = 0;
    m_a = 0; m_b = 0; m_res = 0;
    m_ovf = 1'b0; m_done = 1'b0;
  endfunction

  function automatic void model_step(input logic kv, input logic [3:0] k);
    int sum;
    exp_t e;
    m_done = 1'b0;
    if (m_mode == 2) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_mode = 3;
        m_done = 1'b1;
      end
      return;
    end
    if (!kv || k >= 4'hC) return;
    if (k == 4'hB) begin
      model_reset();
      return;
    end
    if (m_mode == 3) begin
      if (k <= 4'd9) begin
        m_a = int'(k); m_b = 0; m_res = 0; m_ovf = 1'b0; m_nd = 1; m_mode = 0;
      end else begin
        m_a = m_res; m_b = 0; m_ovf = 1'b0; m_nd = 0; m_mode = 1;
      end
      return;
    end
    if (k <= 4'd9) begin
      if (m_nd < D) begin
        if (m_mode == 0) m_a = (m_a * 10 + int'(k)) % P;
        else             m_b = (m_b * 10 + int'(k)) % P;
        m_nd++;
      end
    end else if (m_mode == 0) begin
      m_mode = 1;
      m_nd = 0;
    end else begin
      sum   = m_a + m_b;
      m_res = sum % P;
      m_ovf = (sum >= P);
      m_mode = 2;
      m_cnt = D;
      e.res = to_bcd(m_res);
      e.ovf = m_ovf;
      e.a   = to_bcd(m_a);
      e.b   = to_bcd(m_b);
      sb.push_back(e);
    end
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      logic [W-1:0] disp_exp;
      chk("fase", W'(fase), W'(m_mode));
      chk("busy", W'(busy), W'(m_mode == 2));
      chk("done", W'(done), W'(m_done));
      chk("num_digits", W'(num_digits), W'(m_nd));
      chk("operand_a", operand_a, to_bcd(m_a));
      chk("operand_b", operand_b, to_bcd(m_b));
      case (m_mode)
        0:       disp_exp = to_bcd(m_a);
        3:       disp_exp = to_bcd(m_res);
        default: disp_exp = to_bcd(m_b);
      endcase
      chk("display", display, disp_exp);
      if (m_mode != 2) begin
        chk("resultado", resultado, to_bcd(m_res));
        chk("overflow", W'(overflow), W'(m_ovf));
      end
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL sb_unexpected_done: got done=1, expected no pending add");
        end else begin
          e = sb.pop_front();
          chk("sb_resultado", resultado, e.res);
          chk("sb_overflow", W'(overflow), W'(e.ovf));
          chk("sb_operand_a", operand_a, e.a);
          chk("sb_operand_b", operand_b, e.b);
          $display("add %h + %h -> %h ovf=%0b", operand_a, operand_b, resultado, overflow);
        end
      end
    end
  end

  task automatic cycle(input logic kv, input logic [3:0] k);
    @(negedge clk);
    key_valid = kv;
    key = k;
    @(posedge clk);
    if (rst) model_reset();
    else     model_step(kv, k);
  endtask

  // '.' is an idle cycle (random key with key_valid low); hex characters are keys.
  task automatic run(input string s);
    byte c;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      if (c >= "0" && c <= "9")      cycle(1'b1, 4'(c - "0"));
      else if (c >= "A" && c <= "F") cycle(1'b1, 4'(c - "A" + 10));
      else                           cycle(1'b0, 4'($urandom_range(0, 15)));
    end
  endtask

  task automatic async_reset();
    #1 rst = 1'b1;
    model_reset();
    sb.delete();
    cycle(1'b0, 4'h0);
    cycle(1'b0, 4'h0);
    #1 rst = 1'b0;
  endtask

  initial begin
    int r;
    model_reset();
    rst = 1'b1;
    cycle(1'b0, 4'h0);
    mon_en = 1'b1;
    cycle(1'b0, 4'h0);
    #1 rst = 1'b0;

    run("1234A5678A......");
    run("B9999A0001A......");
    run("B12345AA......");
    run("B1234A5678A......A88A......");
    run("B1111A2222A3BA......B..");
    run("CDEFAACF......");
    run("B1234A5678A..");
    async_reset();
    run("0007A0003A......");
    run("5A......7A6A......B");

    repeat (400) begin
      r = $urandom_range(0, 99);
      if (r < 55)      cycle(1'b1, 4'($urandom_range(0, 9)));
      else if (r < 75) cycle(1'b1, 4'hA);
      else if (r < 78) cycle(1'b1, 4'hB);
      else if (r < 86) cycle(1'b1, 4'($urandom_range(12, 15)));
      else if (r < 98) cycle(1'b0, 4'($urandom_range(0, 15)));
      else             async_reset();
    end

    for (int i = 0; i < 20 && sb.size() != 0; i++) cycle(1'b0, 4'h0);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL sb_drain: got %0d pending results, expected 0", sb.size());
    end
    cycle(1'b0, 4'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
